// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: core vs. debug/loader.
// Round-robin between ports, with a bounded exclusive debug burst under d_lock.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    // core port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    // debug/loader port
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {StRr, StDlock} state_e;

    state_e           state;
    logic             last_dbg;   // 1: debug won the most recent grant
    logic [CNT_W-1:0] burst_cnt;
    logic             c_rv_q;
    logic             d_rv_q;

    logic rr_c, rr_d, lock_active, forced_c, gnt_c, gnt_d;

    always_comb begin
        rr_c        = c_req & (~d_req | last_dbg);
        rr_d        = d_req & ~rr_c;
        lock_active = (state == StDlock) & d_req & d_lock;
        forced_c    = (burst_cnt == BURST_MAX) & c_req;
        if (lock_active) begin
            gnt_c = forced_c;
            gnt_d = ~forced_c;
        end else begin
            gnt_c = rr_c;
            gnt_d = rr_d;
        end
    end

    // Outputs are held at their reset values while reset is asserted.
    assign c_gnt    = gnt_c & ~reset;
    assign d_gnt    = gnt_d & ~reset;
    assign c_rvalid = c_rv_q & ~reset;
    assign d_rvalid = d_rv_q & ~reset;
    assign c_rdata  = mem_rd;
    assign d_rdata  = mem_rd;

    assign mem_a  = d_gnt ? d_addr  : c_addr;
    assign mem_wd = d_gnt ? d_wdata : c_wdata;
    assign mem_we = (c_gnt & c_we) | (d_gnt & d_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StRr;
            last_dbg  <= 1'b1;
            burst_cnt <= '0;
            c_rv_q    <= 1'b0;
            d_rv_q    <= 1'b0;
        end else begin
            c_rv_q <= c_gnt & ~c_we;
            d_rv_q <= d_gnt & ~d_we;
            if (c_gnt) begin
                last_dbg <= 1'b0;
            end else if (d_gnt) begin
                last_dbg <= 1'b1;
            end
            case (state)
                StRr: begin
                    if (d_gnt & d_lock) begin
                        state     <= StDlock;
                        burst_cnt <= CNT_W'(1);
                    end
                end
                StDlock: begin
                    if (!(d_req & d_lock)) begin
                        state     <= StRr;
                        burst_cnt <= '0;
                    end else if (c_gnt) begin
                        burst_cnt <= '0;
                    end else if (burst_cnt != BURST_MAX) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= StRr;
            endcase
        end
    end

endmodule
